fifo_syn: RTL and testbench

Single-clock synchronous FIFO with a registered read port and full/empty status flags. It buffers DEPTH words of WIDTH bits between a producer and a consumer in the same clock domain. It is a generic leaf block that the surrounding datapath instantiates wherever a small elastic buffer is needed.

---
 rtl/fifo_syn.sv | 58 +++++
 tb/tb_fifo_syn.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_syn.sv
// fifo_syn: single-clock FIFO, DEPTH x WIDTH, registered read port.
// Ports: clk, rst_n (sync, active-high), wr, rd, data in; q, full, empty out.
module fifo_syn #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty
);

  localparam int ADDR = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR:0]    wptr;
  logic [ADDR:0]    rptr;
  logic             do_wr;
  logic             do_rd;

  // Extra MSB on each pointer tells full apart from empty.
  assign empty = (wptr == rptr);
  assign full  = (wptr[ADDR-1:0] == rptr[ADDR-1:0]) &&
                 (wptr[ADDR] != rptr[ADDR]);

  // A read frees a slot on the same edge, so a write
  // into a full FIFO is taken when paired with a read.
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wptr <= '0;
      rptr <= '0;
      q    <= '0;
    end else begin
      if (do_wr) begin
        wptr <= wptr + 1'b1;
      end
      if (do_rd) begin
        q    <= mem[rptr[ADDR-1:0]];
        rptr <= rptr + 1'b1;
      end
    end
  end

  // Storage has no reset; only the write is blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst_n && do_wr) begin
      mem[wptr[ADDR-1:0]] <= data;
    end
  end

endmodule

// File: tb/tb_fifo_syn.sv
// tb_fifo_syn: directed and randomized bench for fifo_syn.
// A queue-based model is compared with the DUT on every falling edge.
module tb_fifo_syn;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk;
  logic             rst_n;
  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] q;
  logic             full;
  logic             empty;

  int checks;
  int errors;

  fifo_syn #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (wr),
    .rd    (rd),
    .data  (data),
    .q     (q),
    .full  (full),
    .empty (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a plain queue of words plus the last word read.
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] m_q;

  always @(posedge clk) begin
    bit rd_ok;
    bit wr_ok;
    if (rst_n) begin
      mq.delete();
      m_q = '0;
    end else begin
      rd_ok = rd && (mq.size() > 0);
      wr_ok = wr && ((mq.size() < DEPTH) || rd_ok);
      if (rd_ok) m_q = mq.pop_front();
      if (wr_ok) mq.push_back(data);
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_q", 32'(q), 32'(m_q));
    chk("cmp_empty", 32'(empty), 32'(mq.size() == 0));
    chk("cmp_full", 32'(full), 32'(mq.size() == DEPTH));
  end

  // Inputs change 1 time unit after the rising edge; outputs of that
  // edge are then settled when the task returns.
  task automatic step(input logic r, input logic w, input logic rr,
                      input logic [WIDTH-1:0] d);
    rst_n = r;
    wr    = w;
    rd    = rr;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] fill [8];
  logic [WIDTH-1:0] wv;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    wr    = 1'b0;
    rd    = 1'b0;
    data  = '0;
    fill = '{8'hab, 8'h12, 8'h34, 8'h56, 8'h78, 8'hcd, 8'hcc, 8'hdd};

    // Reset
    repeat (4) step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("model_rst_q", 32'(m_q), 32'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("rd_empty_q", 32'(q), 32'h00);
    chk("rd_empty_e", 32'(empty), 32'd1);

    // Fill
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, fill[i]);
      if (i == 0) chk("fill_nempty", 32'(empty), 32'd0);
      if (i < 7) chk("fill_nfull", 32'(full), 32'd0);
    end
    chk("fill_full", 32'(full), 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'hee);
    chk("ovf_full", 32'(full), 32'd1);

    // Drain
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("drain_q", 32'(q), 32'(fill[i]));
      chk("model_drain_q", 32'(m_q), 32'(fill[i]));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("udf_q", 32'(q), 32'hdd);

    // Simultaneous at full
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, fill[i]);
    step(1'b0, 1'b1, 1'b1, 8'h44);
    chk("rw_full_q", 32'(q), 32'hab);
    chk("rw_full_f", 32'(full), 32'd1);
    for (int i = 1; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("rw_full_drain", 32'(q), 32'(fill[i]));
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("rw_full_last", 32'(q), 32'h44);
    chk("rw_full_empty", 32'(empty), 32'd1);

    // Simultaneous at empty
    step(1'b0, 1'b1, 1'b1, 8'h55);
    chk("rw_empty_q", 32'(q), 32'h44);
    chk("rw_empty_e", 32'(empty), 32'd0);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("rw_empty_rd", 32'(q), 32'h55);
    chk("rw_empty_e2", 32'(empty), 32'd1);

    // Wrap with interleaved pairs
    for (int i = 0; i < 12; i++) begin
      wv = 8'(8'h60 + i * 7);
      step(1'b0, 1'b1, 1'b0, wv);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("wrap_q", 32'(q), 32'(wv));
    end

    // Reset mid-operation with 3 entries held
    step(1'b0, 1'b1, 1'b0, 8'h91);
    step(1'b0, 1'b1, 1'b0, 8'h92);
    step(1'b0, 1'b1, 1'b0, 8'h93);
    step(1'b1, 1'b1, 1'b1, 8'h94);
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_full", 32'(full), 32'd0);
    chk("mrst_q", 32'(q), 32'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("mrst_rd_q", 32'(q), 32'h00);
    chk("mrst_rd_e", 32'(empty), 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("mrst_new", 32'(q), 32'h77);

    // Randomized traffic with biased fill/drain phases
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = ((i / 200) % 2 == 0) ? 70 : 30;
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < bias),
           ($urandom_range(0, 99) < (100 - bias)),
           8'($urandom));
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
